// File: rtl/spart_mm.sv
// spart_mm: memory-mapped 8N1 UART responder at 0xC004-0xC007.
// Bus writes and read side-effects are captured on the clock negedge. Both
// serial FSMs run on the posedge and act on those captured requests.
module spart_mm #(
  parameter logic [15:0] DB_RESET = 16'd5208,
  parameter logic [15:0] DB_MIN   = 16'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        hit,
  output logic        TX,
  input  logic        RX
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [15:0] divisor;
  logic [15:0] div_eff;
  logic [15:0] reload;
  logic [15:0] half_load;
  logic [7:0]  tx_byte;
  logic        tx_go;
  logic        clr_data;
  logic        clr_stat;
  logic        tx_rdy;
  logic        rx_rdy;
  logic        ovr;
  logic        frm_err;
  logic [7:0]  rx_buf;
  logic        unused_wdata;

  state_t      tx_state, tx_state_nx;
  logic [15:0] tx_cnt, tx_cnt_nx;
  logic [7:0]  tx_sh, tx_sh_nx;
  logic [2:0]  tx_bit, tx_bit_nx;

  state_t      rx_state, rx_state_nx;
  logic [15:0] rx_cnt, rx_cnt_nx;
  logic [7:0]  rx_sh, rx_sh_nx;
  logic [2:0]  rx_bit, rx_bit_nx;
  logic        rx_s1, rx_s2, rx_prev;
  logic        rx_fall;
  logic        rx_done;
  logic        rx_ferr;

  assign unused_wdata = ^wdata[15:8];

  assign hit       = (addr[15:2] == 14'h3001) && (re || we);
  assign div_eff   = (divisor < DB_MIN) ? DB_MIN : divisor;
  assign reload    = div_eff - 16'd1;
  assign half_load = (div_eff >> 1) - 16'd1;
  assign tx_rdy    = (tx_state == S_IDLE);
  assign rx_fall   = rx_prev & ~rx_s2;

  // Read mux: shows state before any clear lands, so the read value is kept.
  always_comb begin
    rdata = 16'hDEAD;
    if (hit) begin
      case (addr[1:0])
        2'd0:    rdata = {8'h00, rx_buf};
        2'd1:    rdata = {12'h000, frm_err, ovr, rx_rdy, tx_rdy};
        2'd2:    rdata = {8'h00, divisor[7:0]};
        default: rdata = {8'h00, divisor[15:8]};
      endcase
    end
  end

  // Bus capture on negedge; clears become one-cycle requests to the posedge side.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor  <= DB_RESET;
      tx_byte  <= '0;
      tx_go    <= 1'b0;
      clr_data <= 1'b0;
      clr_stat <= 1'b0;
    end else begin
      tx_go    <= 1'b0;
      clr_data <= 1'b0;
      clr_stat <= 1'b0;
      if (hit && we) begin
        case (addr[1:0])
          2'd0: if (tx_rdy) begin
            tx_go   <= 1'b1;
            tx_byte <= wdata[7:0];
          end
          2'd2:    divisor[7:0]  <= wdata[7:0];
          2'd3:    divisor[15:8] <= wdata[7:0];
          default: ;
        endcase
      end else if (hit && re) begin
        case (addr[1:0])
          2'd0:    clr_data <= 1'b1;
          2'd1:    clr_stat <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Transmitter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_sh    <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_sh    <= tx_sh_nx;
      tx_bit   <= tx_bit_nx;
    end
  end

  // Transmitter next-state: each state lasts reload+1 = divisor clocks.
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_sh_nx    = tx_sh;
    tx_bit_nx   = tx_bit;
    case (tx_state)
      S_IDLE: if (tx_go) begin
        tx_state_nx = S_START;
        tx_cnt_nx   = reload;
        tx_sh_nx    = tx_byte;
      end
      S_START: if (tx_cnt == 16'd0) begin
        tx_state_nx = S_DATA;
        tx_cnt_nx   = reload;
        tx_bit_nx   = '0;
      end else begin
        tx_cnt_nx = tx_cnt - 16'd1;
      end
      S_DATA: if (tx_cnt == 16'd0) begin
        tx_cnt_nx = reload;
        tx_sh_nx  = {1'b0, tx_sh[7:1]};
        tx_bit_nx = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_state_nx = S_STOP;
      end else begin
        tx_cnt_nx = tx_cnt - 16'd1;
      end
      default: if (tx_cnt == 16'd0) begin
        tx_state_nx = S_IDLE;
      end else begin
        tx_cnt_nx = tx_cnt - 16'd1;
      end
    endcase
  end

  // Serial out decoded from the state register; async reset forces idle-high.
  always_comb begin
    TX = 1'b1;
    if (tx_state == S_START)     TX = 1'b0;
    else if (tx_state == S_DATA) TX = tx_sh[0];
  end

  // RX synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_sh    <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_sh    <= rx_sh_nx;
      rx_bit   <= rx_bit_nx;
    end
  end

  // Receiver next-state: half-bit wait to centre, then full-bit sampling.
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_sh_nx    = rx_sh;
    rx_bit_nx   = rx_bit;
    rx_done     = 1'b0;
    rx_ferr     = 1'b0;
    case (rx_state)
      S_IDLE: if (rx_fall) begin
        rx_state_nx = S_START;
        rx_cnt_nx   = half_load;
      end
      S_START: if (rx_cnt == 16'd0) begin
        rx_cnt_nx = reload;
        rx_bit_nx = '0;
        rx_state_nx = rx_s2 ? S_IDLE : S_DATA;
      end else begin
        rx_cnt_nx = rx_cnt - 16'd1;
      end
      S_DATA: if (rx_cnt == 16'd0) begin
        rx_cnt_nx = reload;
        rx_sh_nx  = {rx_s2, rx_sh[7:1]};
        rx_bit_nx = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_nx = S_STOP;
      end else begin
        rx_cnt_nx = rx_cnt - 16'd1;
      end
      default: if (rx_cnt == 16'd0) begin
        rx_state_nx = S_IDLE;
        rx_done     = rx_s2;
        rx_ferr     = ~rx_s2;
      end else begin
        rx_cnt_nx = rx_cnt - 16'd1;
      end
    endcase
  end

  // Receive buffer and flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_buf  <= '0;
      rx_rdy  <= 1'b0;
      ovr     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      if (rx_done) begin
        rx_buf <= rx_sh;
        rx_rdy <= 1'b1;
      end else if (clr_data) begin
        rx_rdy <= 1'b0;
      end
      if (rx_done && rx_rdy) ovr <= 1'b1;
      else if (clr_stat)     ovr <= 1'b0;
      if (rx_ferr)           frm_err <= 1'b1;
      else if (clr_stat)     frm_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_mm.sv
// Directed testbench for spart_mm: bus register map, TX/RX framing and flags.
module tb_spart_mm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        hit;
  logic        TX;
  logic        RX = 1'b1;

  int asserts = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spart_mm #(.DB_RESET(16'd5208), .DB_MIN(16'd4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we),
    .wdata(wdata), .rdata(rdata), .hit(hit), .TX(TX), .RX(RX)
  );

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk); #1;
    we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    addr = a; re = 1'b1;
    #1 d = rdata;
    @(negedge clk); #1;
    re = 1'b0; addr = '0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input int div);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      RX = bits[i];
      repeat (div) @(posedge clk);
      #1;
    end
    RX = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst_n = 1'b0;
    addr = 16'hC005; re = 1'b1;
    #2;
    asserts++; if (rdata !== 16'h0001) begin failures++; $display("FAIL reset_status got %h want 0001", rdata); end
    asserts++; if (TX !== 1'b1) begin failures++; $display("FAIL reset_tx got %b want 1", TX); end
    re = 1'b0; addr = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    bus_read(16'hC006, v);
    asserts++; if (v !== 16'h0058) begin failures++; $display("FAIL reset_dbl got %h want 0058", v); end
    bus_read(16'hC007, v);
    asserts++; if (v !== 16'h0014) begin failures++; $display("FAIL reset_dbh got %h want 0014", v); end
  endtask

  task automatic test_tx_frame();
    logic [9:0]  fr;
    logic [15:0] v;
    logic        saw_low;
    bus_write(16'hC006, 16'd16);
    bus_write(16'hC007, 16'd0);
    bus_write(16'hC004, 16'h00A5);
    fr = {1'b1, 8'hA5, 1'b0};
    @(posedge clk);
    for (int k = 0; k < 160; k++) begin
      if (k != 0) @(posedge clk);
      #1;
      if (k % 16 == 0 || k % 16 == 15) begin
        asserts++;
        if (TX !== fr[k / 16]) begin failures++; $display("FAIL tx_a5_bit k=%0d got %b want %b", k, TX, fr[k / 16]); end
      end
      if (k == 40) begin
        addr = 16'hC005; re = 1'b1;
        #1;
        asserts++; if (rdata !== 16'h0000) begin failures++; $display("FAIL tx_busy_status got %h want 0000", rdata); end
        #5 re = 1'b0; addr = '0;
      end
      if (k == 72) begin
        addr = 16'hC004; wdata = 16'h00FF; we = 1'b1;
        #6 we = 1'b0; addr = '0; wdata = '0;
      end
    end
    @(posedge clk); #1;
    asserts++; if (TX !== 1'b1) begin failures++; $display("FAIL tx_after_frame got %b want 1", TX); end
    bus_read(16'hC005, v);
    asserts++; if (v !== 16'h0001) begin failures++; $display("FAIL tx_done_status got %h want 0001", v); end
    saw_low = 1'b0;
    repeat (20) begin @(posedge clk); #1 if (TX === 1'b0) saw_low = 1'b1; end
    asserts++; if (saw_low !== 1'b0) begin failures++; $display("FAIL tx_ignored_write got %b want 0", saw_low); end
  endtask

  task automatic test_rx_frame();
    logic [15:0] v;
    send_rx(8'h3C, 1'b1, 16);
    bus_read(16'hC005, v);
    asserts++; if (v !== 16'h0003) begin failures++; $display("FAIL rx_status got %h want 0003", v); end
    bus_read(16'hC004, v);
    asserts++; if (v !== 16'h003C) begin failures++; $display("FAIL rx_data got %h want 003C", v); end
    bus_read(16'hC005, v);
    asserts++; if (v !== 16'h0001) begin failures++; $display("FAIL rx_status_cleared got %h want 0001", v); end
  endtask

  task automatic test_overrun();
    logic [15:0] v;
    send_rx(8'h11, 1'b1, 16);
    send_rx(8'h22, 1'b1, 16);
    bus_read(16'hC005, v);
    asserts++; if (v !== 16'h0007) begin failures++; $display("FAIL ovr_status got %h want 0007", v); end
    bus_read(16'hC004, v);
    asserts++; if (v !== 16'h0022) begin failures++; $display("FAIL ovr_data got %h want 0022", v); end
    bus_read(16'hC005, v);
    asserts++; if (v !== 16'h0001) begin failures++; $display("FAIL ovr_cleared got %h want 0001", v); end
  endtask

  task automatic test_framing();
    logic [15:0] v;
    send_rx(8'h55, 1'b0, 16);
    bus_read(16'hC005, v);
    asserts++; if (v !== 16'h0009) begin failures++; $display("FAIL frm_status got %h want 0009", v); end
    bus_read(16'hC004, v);
    asserts++; if (v !== 16'h0022) begin failures++; $display("FAIL frm_buf_kept got %h want 0022", v); end
    bus_read(16'hC005, v);
    asserts++; if (v !== 16'h0001) begin failures++; $display("FAIL frm_cleared got %h want 0001", v); end
  endtask

  task automatic test_glitch();
    logic [15:0] v;
    @(posedge clk); #1 RX = 1'b0;
    repeat (3) @(posedge clk);
    #1 RX = 1'b1;
    repeat (40) @(posedge clk);
    bus_read(16'hC005, v);
    asserts++; if (v !== 16'h0001) begin failures++; $display("FAIL glitch_status got %h want 0001", v); end
    send_rx(8'h5A, 1'b1, 16);
    bus_read(16'hC005, v);
    asserts++; if (v !== 16'h0003) begin failures++; $display("FAIL post_glitch_status got %h want 0003", v); end
    bus_read(16'hC004, v);
    asserts++; if (v !== 16'h005A) begin failures++; $display("FAIL post_glitch_data got %h want 005A", v); end
  endtask

  task automatic test_decode();
    @(negedge clk); #1;
    addr = 16'hC008; re = 1'b1;
    #1;
    asserts++; if (hit !== 1'b0) begin failures++; $display("FAIL decode_c008_hit got %b want 0", hit); end
    asserts++; if (rdata !== 16'hDEAD) begin failures++; $display("FAIL decode_c008_rdata got %h want DEAD", rdata); end
    addr = 16'hC003;
    #1;
    asserts++; if (rdata !== 16'hDEAD) begin failures++; $display("FAIL decode_c003_rdata got %h want DEAD", rdata); end
    addr = 16'hC007; re = 1'b0;
    #1;
    asserts++; if (hit !== 1'b0) begin failures++; $display("FAIL decode_noen_hit got %b want 0", hit); end
    re = 1'b1;
    #1;
    asserts++; if (hit !== 1'b1) begin failures++; $display("FAIL decode_c007_hit got %b want 1", hit); end
    asserts++; if (rdata !== 16'h0000) begin failures++; $display("FAIL decode_c007_rdata got %h want 0000", rdata); end
    re = 1'b0; addr = '0;
  endtask

  task automatic test_clamp();
    logic [9:0]  fr;
    logic [15:0] v;
    bus_write(16'hC006, 16'd2);
    bus_read(16'hC006, v);
    asserts++; if (v !== 16'h0002) begin failures++; $display("FAIL clamp_dbl_read got %h want 0002", v); end
    bus_write(16'hC004, 16'h0096);
    fr = {1'b1, 8'h96, 1'b0};
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      if (k != 0) @(posedge clk);
      #1;
      if (k % 4 == 0 || k % 4 == 3) begin
        asserts++;
        if (TX !== fr[k / 4]) begin failures++; $display("FAIL clamp_bit k=%0d got %b want %b", k, TX, fr[k / 4]); end
      end
    end
    @(posedge clk); #1;
    asserts++; if (TX !== 1'b1) begin failures++; $display("FAIL clamp_after got %b want 1", TX); end
    bus_read(16'hC005, v);
    asserts++; if (v !== 16'h0001) begin failures++; $display("FAIL clamp_status got %h want 0001", v); end
  endtask

  task automatic test_mid_reset();
    logic [9:0] fr;
    bus_write(16'hC006, 16'd16);
    bus_write(16'hC004, 16'h00C3);
    @(posedge clk);
    repeat (50) @(posedge clk);
    #1;
    asserts++; if (TX !== 1'b0) begin failures++; $display("FAIL midrst_pre_tx got %b want 0", TX); end
    rst_n = 1'b0;
    #1;
    asserts++; if (TX !== 1'b1) begin failures++; $display("FAIL midrst_tx got %b want 1", TX); end
    addr = 16'hC005; re = 1'b1;
    #1;
    asserts++; if (rdata !== 16'h0001) begin failures++; $display("FAIL midrst_status got %h want 0001", rdata); end
    addr = 16'hC006;
    #1;
    asserts++; if (rdata !== 16'h0058) begin failures++; $display("FAIL midrst_dbl got %h want 0058", rdata); end
    re = 1'b0; addr = '0;
    @(negedge clk); #1 rst_n = 1'b1;
    bus_write(16'hC006, 16'd16);
    bus_write(16'hC007, 16'd0);
    bus_write(16'hC004, 16'h003C);
    fr = {1'b1, 8'h3C, 1'b0};
    @(posedge clk);
    for (int k = 0; k < 160; k++) begin
      if (k != 0) @(posedge clk);
      #1;
      if (k % 16 == 0 || k % 16 == 15) begin
        asserts++;
        if (TX !== fr[k / 16]) begin failures++; $display("FAIL midrst_frame k=%0d got %b want %b", k, TX, fr[k / 16]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_rx_frame();
    test_overrun();
    test_framing();
    test_glitch();
    test_decode();
    test_clamp();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got no completion want finish by 2ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spart_mm.md
# spart_mm

Memory-mapped serial port (8N1 UART transmitter and receiver) that acts as a bus responder to the CPU's external data interface (addr/re/we/wdata/rdata). It occupies addresses 0xC004–0xC007, alongside the LED (0xC000) and switch (0xC001) responders in the top level. It supplies read data and a `hit` flag so the top level can mux `rdata` between responders. It drives the board TX pin and samples the board RX pin.

## Interface
Parameters:
- `DB_RESET`, 16'd5208: baud divisor reset value, in clocks per bit (50 MHz / 9600).
- `DB_MIN`, 16'd4: smallest divisor honoured; smaller programmed values are treated as `DB_MIN`.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `addr`, input, 16: CPU external address.
- `re`, input, 1: CPU read enable.
- `we`, input, 1: CPU write enable.
- `wdata`, input, 16: CPU write data; only [7:0] is used.
- `rdata`, output, 16: read data. Combinational; 16'hDEAD when `hit` is 0.
- `hit`, output, 1: asserted when `addr` is in 0xC004–0xC007 and (`re` or `we`) is 1. Combinational.
- `TX`, output, 1: serial out, idles high.
- `RX`, input, 1: serial in, asynchronous.

## Operation
Register map:
- 0xC004 DATA
  - Write: load the TX byte and start a frame. The write is ignored if `tx_rdy` is 0.
  - Read: returns {8'h00, rx_buf}. The read clears `rx_rdy`.
- 0xC005 STATUS, read-only: {12'h000, frm_err, ovr, rx_rdy, tx_rdy}. A read clears `ovr` and `frm_err`.
- 0xC006 DBL: write sets divisor[7:0]; read returns {8'h00, divisor[7:0]}.
- 0xC007 DBH: write sets divisor[15:8]; read returns {8'h00, divisor[15:8]}.

Bus side:
- Writes and read side-effects (flag clears) are applied on the negedge of `clk` when `hit` is 1 and `we` or `re` is 1. This matches the timing of the other memory-mapped responders.
- Simultaneous `re` and `we` is treated as a write only.

Transmitter FSM (posedge), states IDLE → START → DATA → STOP → IDLE:
- IDLE: `TX`=1, `tx_rdy`=1.
- A captured DATA write moves the FSM to START at the next posedge, and `tx_rdy` goes to 0.
- Each state holds for `divisor` clocks.
- DATA shifts out 8 bits, LSB first, using a 3-bit bit counter.
- After STOP (`TX`=1) completes, the FSM returns to IDLE and `tx_rdy` returns to 1.

Receiver FSM (posedge), states IDLE → START → DATA → STOP → IDLE:
- `RX` passes through a 2-flop synchroniser. The idle value of the synchronisers is 1.
- IDLE: a synchronised falling edge moves the FSM to START.
- START: waits `divisor`/2 clocks, then resamples.
  - If the sample is high (glitch), return to IDLE.
  - Otherwise enter DATA.
- DATA: samples every `divisor` clocks, 8 bits, LSB first.
- STOP: samples once after `divisor` clocks.
  - Stop bit = 1: `rx_buf` is loaded with the byte and `rx_rdy` is set. If `rx_rdy` was already 1, `ovr` is also set and the new byte overwrites the old one.
  - Stop bit = 0: `frm_err` is set, the byte is discarded, and `rx_buf` and `rx_rdy` are unchanged.
- Return to IDLE immediately after the STOP sample.

Baud and divisor rules:
- The baud counter is 16-bit and loads `max(divisor, DB_MIN) - 1`.
- A divisor write in mid-frame takes effect at the next counter reload.

## Timing
Reset values (asynchronous):
- `TX`=1, `tx_rdy`=1, `rx_rdy`=0, `ovr`=0, `frm_err`=0.
- `rx_buf`=8'h00, `divisor`=`DB_RESET`, both FSMs in IDLE.
- Asserting reset mid-frame aborts the frame immediately and returns `TX` to 1.

Transmit timing:
- A write captured at negedge n gives a start bit beginning at the following posedge.
- Frame length is exactly 10×`divisor` clocks.
- `tx_rdy` reads 0 from the first posedge after the write through the end of the stop bit.

Receive timing:
- `rx_rdy` rises within 3 clocks after the stop-bit centre sample (2 synchroniser stages plus 1 register).

Read/clear interaction:
- `rdata` reflects state before the clearing negedge, so the read value is not lost.
- A read-clear and a flag set in the same cycle resolve as set wins.

## Test plan
- Reset: `rst_n`=0, then `re` at 0xC005 → `rdata`=16'h0001, `TX`=1. Read 0xC006/0xC007 → 16'h0058/16'h0014.
- TX frame: write DBL=16, DBH=0, then DATA=8'hA5. Expect `TX` = 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks. Status=16'h0000 during the frame and 16'h0001 after 160 clocks. A second DATA write mid-frame is ignored.
- RX frame: divisor 16, drive 8'h3C at 16 clocks per bit on `RX`. Expect status=16'h0003; reading 0xC004 returns 16'h003C, then status=16'h0001.
- Overrun/framing:
  - Receive 8'h11 then 8'h22 without reading. Expect status=16'h0007 and DATA=16'h0022; the next status read returns 16'h0001.
  - Receive a frame with the stop bit low. Expect status bit3=1 and `rx_buf` unchanged.
- Glitch and decode:
  - A 3-clock low pulse on `RX` → no `rx_rdy`.
  - `addr`=0xC008 with `re` → `hit`=0 and `rdata`=16'hDEAD.
  - Divisor 2 is clamped: bits last 4 clocks.
- Mid-frame reset: assert `rst_n` during the DATA phase of a TX frame → `TX`=1 and status=16'h0001 immediately. A new frame after release transmits correctly.
